time_param_timer: RTL and testbench

- Parametrised successor of the junction's time-parameter register block.
- Holds NUM_PARAMS programmable phase durations, each with a reset default, and outputs the duration for the requested interval code.
- Adds a built-in countdown timer. The timer loads the selected duration on start, decrements on an external tick enable, and pulses expired at zero.
- Sits between the programming interface and the light-sequencing FSM.

---
 rtl/time_param_timer.sv | 101 ++++++++++
 tb/tb_time_param_timer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/time_param_timer.sv
// Programmable phase-duration register bank with an integrated countdown timer.
// Feeds the light-sequencing FSM with the selected duration and an expiry pulse.
module time_param_timer #(
  parameter int WIDTH = 4,
  parameter int NUM_PARAMS = 3,
  parameter logic [NUM_PARAMS*WIDTH-1:0] DEFAULTS = {4'd2, 4'd3, 4'd6},
  localparam int SEL_W = $clog2(NUM_PARAMS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             prog_sync,
  input  logic [SEL_W-1:0] selector,
  input  logic [WIDTH-1:0] time_value,
  input  logic [SEL_W-1:0] interval,
  input  logic             start,
  input  logic             tick,
  output logic [WIDTH:0]   value,
  output logic [WIDTH:0]   remaining,
  output logic             busy,
  output logic             expired
);

  localparam logic [SEL_W-1:0] NP_S = SEL_W'(NUM_PARAMS);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] param [NUM_PARAMS];
  logic [WIDTH:0]   sel_dur;
  logic [WIDTH-1:0] wr_val;

  always_comb begin
    sel_dur = {1'b0, param[0]};
    for (int i = 0; i < NUM_PARAMS; i++) begin
      if (interval == SEL_W'(i)) sel_dur = {1'b0, param[i]};
    end
    if (interval == NP_S) sel_dur = {param[0], 1'b0};
  end

  // Zero is never a legal duration; clamp to one tick.
  assign wr_val = (time_value == '0) ? WIDTH'(1) : time_value;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PARAMS; i++)
        param[i] <= DEFAULTS[i*WIDTH +: WIDTH];
    end else if (prog_sync) begin
      for (int i = 0; i < NUM_PARAMS; i++) begin
        if (selector == '0)
          param[i] <= DEFAULTS[i*WIDTH +: WIDTH];
        else if (selector == SEL_W'(i + 1))
          param[i] <= wr_val;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) value <= '0;
    else        value <= sel_dur;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      remaining <= '0;
      busy      <= 1'b0;
      expired   <= 1'b0;
    end else begin
      expired <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            remaining <= sel_dur;
            state     <= RUN;
            busy      <= 1'b1;
          end
        end
        RUN: begin
          if (start) begin
            remaining <= sel_dur;
          end else if (tick && remaining > (WIDTH+1)'(1)) begin
            remaining <= remaining - 1'b1;
          end else if (tick && remaining == (WIDTH+1)'(1)) begin
            remaining <= '0;
            expired   <= 1'b1;
            state     <= IDLE;
            busy      <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_time_param_timer.sv
// Directed bench for time_param_timer: duration select, programming,
// countdown, reload priority and asynchronous reset.
module tb_time_param_timer;

  logic       clk;
  logic       rst_n;
  logic       prog_sync;
  logic [1:0] selector;
  logic [3:0] time_value;
  logic [1:0] interval;
  logic       start;
  logic       tick;
  logic [4:0] value;
  logic [4:0] remaining;
  logic       busy;
  logic       expired;

  int tests = 0;
  int fails = 0;

  time_param_timer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .prog_sync  (prog_sync),
    .selector   (selector),
    .time_value (time_value),
    .interval   (interval),
    .start      (start),
    .tick       (tick),
    .value      (value),
    .remaining  (remaining),
    .busy       (busy),
    .expired    (expired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    tests++;
    if ({value, remaining, busy, expired} !== 12'd0) begin
      fails++;
      $display("FAIL reset_outputs got v=%0d r=%0d b=%0b e=%0b want 0",
               value, remaining, busy, expired);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_select();
    logic [4:0] exp_v [4];
    exp_v[0] = 5'd6;
    exp_v[1] = 5'd3;
    exp_v[2] = 5'd2;
    exp_v[3] = 5'd12;
    for (int i = 0; i < 4; i++) begin
      interval = 2'(i);
      step();
      tests++;
      if (value !== exp_v[i]) begin
        fails++;
        $display("FAIL select_%0d got %0d want %0d", i, value, exp_v[i]);
      end
    end
  endtask

  task automatic test_program();
    interval   = 2'd0;
    prog_sync  = 1'b1;
    selector   = 2'd1;
    time_value = 4'd9;
    step();
    tests++;
    if (value !== 5'd6) begin
      fails++;
      $display("FAIL prog_prewrite got %0d want 6", value);
    end
    prog_sync = 1'b0;
    interval  = 2'd3;
    step();
    tests++;
    if (value !== 5'd18) begin
      fails++;
      $display("FAIL prog_double got %0d want 18", value);
    end
    prog_sync = 1'b1;
    selector  = 2'd0;
    step();
    prog_sync = 1'b0;
    interval  = 2'd0;
    step();
    tests++;
    if (value !== 5'd6) begin
      fails++;
      $display("FAIL prog_restore got %0d want 6", value);
    end
  endtask

  task automatic test_clamp();
    prog_sync  = 1'b1;
    selector   = 2'd2;
    time_value = 4'd0;
    step();
    prog_sync = 1'b0;
    interval  = 2'd1;
    step();
    tests++;
    if (value !== 5'd1) begin
      fails++;
      $display("FAIL clamp got %0d want 1", value);
    end
    prog_sync = 1'b1;
    selector  = 2'd0;
    step();
    prog_sync = 1'b0;
    step();
    tests++;
    if (value !== 5'd3) begin
      fails++;
      $display("FAIL clamp_restore got %0d want 3", value);
    end
  endtask

  task automatic test_countdown();
    int exp_cnt;
    interval = 2'd2;
    start    = 1'b1;
    step();
    start = 1'b0;
    tests++;
    if (remaining !== 5'd2 || busy !== 1'b1 || expired !== 1'b0) begin
      fails++;
      $display("FAIL cd_load got r=%0d b=%0b e=%0b want r=2 b=1 e=0",
               remaining, busy, expired);
    end
    exp_cnt = 0;
    repeat (3) begin
      step();
      if (expired) exp_cnt++;
    end
    tick = 1'b1;
    step();
    tick = 1'b0;
    tests++;
    if (remaining !== 5'd1 || busy !== 1'b1 || expired !== 1'b0) begin
      fails++;
      $display("FAIL cd_tick1 got r=%0d b=%0b e=%0b want r=1 b=1 e=0",
               remaining, busy, expired);
    end
    repeat (3) begin
      step();
      if (expired) exp_cnt++;
    end
    tick = 1'b1;
    step();
    tick = 1'b0;
    tests++;
    if (remaining !== 5'd0 || busy !== 1'b0 || expired !== 1'b1) begin
      fails++;
      $display("FAIL cd_expire got r=%0d b=%0b e=%0b want r=0 b=0 e=1",
               remaining, busy, expired);
    end
    repeat (3) begin
      step();
      if (expired) exp_cnt++;
    end
    tests++;
    if (exp_cnt !== 0 || remaining !== 5'd0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL cd_after got extra_exp=%0d r=%0d b=%0b want 0 0 0",
               exp_cnt, remaining, busy);
    end
  endtask

  task automatic test_back_to_back();
    interval = 2'd0;
    start    = 1'b1;
    tick     = 1'b1;
    step();
    start = 1'b0;
    tick  = 1'b0;
    tests++;
    if (remaining !== 5'd6 || busy !== 1'b1) begin
      fails++;
      $display("FAIL idle_start_tick got r=%0d b=%0b want r=6 b=1",
               remaining, busy);
    end
    interval = 2'd1;
    start    = 1'b1;
    step();
    start = 1'b0;
    tick  = 1'b1;
    step();
    tick = 1'b0;
    tests++;
    if (remaining !== 5'd2) begin
      fails++;
      $display("FAIL reload_pre got r=%0d want 2", remaining);
    end
    start = 1'b1;
    tick  = 1'b1;
    step();
    start = 1'b0;
    tick  = 1'b0;
    tests++;
    if (remaining !== 5'd3 || busy !== 1'b1 || expired !== 1'b0) begin
      fails++;
      $display("FAIL reload_wins got r=%0d b=%0b e=%0b want r=3 b=1 e=0",
               remaining, busy, expired);
    end
  endtask

  task automatic test_reset_midrun();
    int exp_cnt;
    prog_sync  = 1'b1;
    selector   = 2'd1;
    time_value = 4'd5;
    step();
    prog_sync = 1'b0;
    interval  = 2'd0;
    start     = 1'b1;
    step();
    start = 1'b0;
    tests++;
    if (remaining !== 5'd5 || busy !== 1'b1) begin
      fails++;
      $display("FAIL mid_load got r=%0d b=%0b want r=5 b=1", remaining, busy);
    end
    prog_sync  = 1'b1;
    selector   = 2'd1;
    time_value = 4'd7;
    step();
    prog_sync = 1'b0;
    step();
    tests++;
    if (remaining !== 5'd5 || busy !== 1'b1 || value !== 5'd7) begin
      fails++;
      $display("FAIL mid_write got r=%0d b=%0b v=%0d want r=5 b=1 v=7",
               remaining, busy, value);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({value, remaining, busy, expired} !== 12'd0) begin
      fails++;
      $display("FAIL mid_reset got v=%0d r=%0d b=%0b e=%0b want 0",
               value, remaining, busy, expired);
    end
    exp_cnt = 0;
    repeat (2) begin
      step();
      if (expired) exp_cnt++;
    end
    rst_n = 1'b1;
    step();
    if (expired) exp_cnt++;
    tests++;
    if (exp_cnt !== 0 || value !== 5'd6 || busy !== 1'b0) begin
      fails++;
      $display("FAIL post_reset got exp=%0d v=%0d b=%0b want 0 6 0",
               exp_cnt, value, busy);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    prog_sync  = 1'b0;
    selector   = 2'd0;
    time_value = 4'd0;
    interval   = 2'd0;
    start      = 1'b0;
    tick       = 1'b0;
    test_reset();
    test_select();
    test_program();
    test_clamp();
    test_countdown();
    test_back_to_back();
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
